// File: rtl/spi_bank_read_rgb_64.sv
// Bank readout engine: snapshots one of eight 256-bit banks and
// streams it as 32 bytes over a valid/ready byte interface.
module spi_bank_read_rgb_64 #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [255:0] DATA_00,
  input  logic [255:0] DATA_01,
  input  logic [255:0] DATA_02,
  input  logic [255:0] DATA_03,
  input  logic [255:0] DATA_04,
  input  logic [255:0] DATA_05,
  input  logic [255:0] DATA_06,
  input  logic [255:0] DATA_07,
  input  logic         START,
  input  logic [7:0]   BANK,
  output logic [7:0]   BYTE_OUT,
  output logic         BYTE_VALID,
  input  logic         BYTE_READY,
  output logic         BUSY,
  output logic         DONE,
  output logic         ERR
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    FINISH
  } state_t;

  state_t       state;
  logic [255:0] snap;
  logic [4:0]   cnt;
  logic [255:0] sel;
  logic         bank_ok;

  function automatic logic [7:0] pick(
    input logic [255:0] d,
    input logic [4:0]   n
  );
    logic [4:0] idx;
    idx = MSB_FIRST ? (5'd31 - n) : n;
    return d[{idx, 3'b000} +: 8];
  endfunction

  assign bank_ok = (BANK[7:3] == 5'd0);

  always_comb begin
    sel = '0;
    unique case (BANK[2:0])
      3'd0: sel = DATA_00;
      3'd1: sel = DATA_01;
      3'd2: sel = DATA_02;
      3'd3: sel = DATA_03;
      3'd4: sel = DATA_04;
      3'd5: sel = DATA_05;
      3'd6: sel = DATA_06;
      3'd7: sel = DATA_07;
    endcase
  end

  // BYTE_OUT is preloaded one edge ahead so the next byte is ready
  // in the cycle right after a transfer, with no bubble.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      snap       <= '0;
      cnt        <= '0;
      BYTE_OUT   <= '0;
      BYTE_VALID <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      ERR        <= 1'b0;
    end else begin
      DONE <= 1'b0;
      ERR  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (START) begin
            if (bank_ok) begin
              snap       <= sel;
              cnt        <= '0;
              state      <= SEND;
              BUSY       <= 1'b1;
              BYTE_VALID <= 1'b1;
              BYTE_OUT   <= pick(sel, 5'd0);
            end else begin
              ERR <= 1'b1;
            end
          end
        end
        SEND: begin
          if (BYTE_READY) begin
            if (cnt == 5'd31) begin
              state      <= FINISH;
              BYTE_VALID <= 1'b0;
              BYTE_OUT   <= '0;
              DONE       <= 1'b1;
            end else begin
              cnt      <= cnt + 5'd1;
              BYTE_OUT <= pick(snap, cnt + 5'd1);
            end
          end
        end
        FINISH: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_bank_read_rgb_64.sv
// Bench for spi_bank_read_rgb_64: MSB-first and LSB-first instances
// share stimulus and are checked against a byte-queue model.
module tb_spi_bank_read_rgb_64;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic [255:0] data [8];
  logic         START = 1'b0;
  logic [7:0]   BANK = '0;
  logic         BYTE_READY = 1'b0;

  logic [7:0] om, ol;
  logic       vm, bm, dm, em;
  logic       vl, bl, dl, el;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  spi_bank_read_rgb_64 #(.MSB_FIRST(1'b1)) dut_m (
    .CLK(CLK), .RST(RST),
    .DATA_00(data[0]), .DATA_01(data[1]), .DATA_02(data[2]),
    .DATA_03(data[3]), .DATA_04(data[4]), .DATA_05(data[5]),
    .DATA_06(data[6]), .DATA_07(data[7]),
    .START(START), .BANK(BANK),
    .BYTE_OUT(om), .BYTE_VALID(vm), .BYTE_READY(BYTE_READY),
    .BUSY(bm), .DONE(dm), .ERR(em)
  );

  spi_bank_read_rgb_64 #(.MSB_FIRST(1'b0)) dut_l (
    .CLK(CLK), .RST(RST),
    .DATA_00(data[0]), .DATA_01(data[1]), .DATA_02(data[2]),
    .DATA_03(data[3]), .DATA_04(data[4]), .DATA_05(data[5]),
    .DATA_06(data[6]), .DATA_07(data[7]),
    .START(START), .BANK(BANK),
    .BYTE_OUT(ol), .BYTE_VALID(vl), .BYTE_READY(BYTE_READY),
    .BUSY(bl), .DONE(dl), .ERR(el)
  );

  typedef struct {
    int bank;
    bit exp_err;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [31:0] all_out();
    return {om, vm, bm, dm, em, ol, vl, bl, dl, el};
  endfunction

  // mode: 0 ready always, 1 pattern 1,0,0, 2 random
  task automatic readout(input int bank, input int mode,
                         input int abort_at, input int disturb_at);
    logic [7:0]   qm[$];
    logic [7:0]   ql[$];
    logic [255:0] s;
    int           got;
    bit           rdy;
    bit           fin;
    s = data[bank];
    for (int i = 0; i < 32; i++) begin
      qm.push_back(s[255:248]);
      s = s << 8;
    end
    s = data[bank];
    for (int i = 0; i < 32; i++) begin
      ql.push_back(s[7:0]);
      s = s >> 8;
    end
    START = 1'b1;
    BANK  = bank[7:0];
    BYTE_READY = 1'b0;
    step();
    START = 1'b0;
    got = 0;
    fin = 1'b0;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      if (got == 32) begin
        chk("done_m", {31'd0, dm}, 1);
        chk("done_l", {31'd0, dl}, 1);
        chk("fin_valid", {30'd0, vm, vl}, 0);
        chk("fin_busy", {30'd0, bm, bl}, 2'b11);
        chk("fin_out", {om, ol}, 0);
        step();
        chk("idle_busy", {30'd0, bm, bl}, 0);
        chk("idle_done", {30'd0, dm, dl}, 0);
        fin = 1'b1;
      end else begin
        chk("valid", {30'd0, vm, vl}, 2'b11);
        chk("byte_m", {24'd0, om}, {24'd0, qm[0]});
        chk("byte_l", {24'd0, ol}, {24'd0, ql[0]});
        chk("no_err_done", {28'd0, em, el, dm, dl}, 0);
        if (got == abort_at) begin
          RST = 1'b1;
          #1;
          chk("abort_now", all_out(), 0);
          step();
          chk("abort_held", all_out(), 0);
          RST = 1'b0;
          BYTE_READY = 1'b0;
          step();
          chk("abort_idle", all_out(), 0);
          return;
        end
        if (mode == 0) rdy = 1'b1;
        else if (mode == 1) rdy = (cyc % 3 == 0);
        else rdy = ($urandom % 4) != 0;
        BYTE_READY = rdy;
        if (got == disturb_at) begin
          data[bank] = rnd256();
          START = 1'b1;
          BANK  = 8'd5;
        end
        step();
        START = 1'b0;
        if (rdy) begin
          got++;
          void'(qm.pop_front());
          void'(ql.pop_front());
        end
      end
    end
    chk("finished", {31'd0, fin}, 1);
  endtask

  initial begin
    vecs[0] = '{3, 1'b0};
    vecs[1] = '{8, 1'b1};
    vecs[2] = '{0, 1'b0};
    vecs[3] = '{255, 1'b1};
    vecs[4] = '{7, 1'b0};
    vecs[5] = '{100, 1'b1};
    vecs[6] = '{5, 1'b0};
    vecs[7] = '{9, 1'b1};
    for (int i = 0; i < 8; i++) data[i] = rnd256();

    #2 RST = 1'b1;
    #1 chk("reset_async", all_out(), 0);
    step();
    chk("reset_held", all_out(), 0);
    RST = 1'b0;
    step();
    chk("idle_after_reset", all_out(), 0);

    // Known pattern: byte k = k from the top of DATA_03
    for (int k = 0; k < 32; k++) data[3][255 - 8*k -: 8] = k[7:0];
    START = 1'b1;
    BANK = 8'd3;
    BYTE_READY = 1'b1;
    step();
    START = 1'b0;
    for (int n = 0; n < 32; n++) begin
      chk("seq_valid", {30'd0, vm, vl}, 2'b11);
      chk("seq_m", {24'd0, om}, n);
      chk("seq_l", {24'd0, ol}, 31 - n);
      step();
    end
    chk("seq_done", {29'd0, dm, bm, vm}, 3'b110);
    step();
    chk("seq_idle", {29'd0, dm, bm, vm}, 0);

    // Table of START attempts, legal and out-of-range banks
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].exp_err) begin
        START = 1'b1;
        BANK = vecs[i].bank[7:0];
        step();
        START = 1'b0;
        chk("err_pulse", {30'd0, em, el}, 2'b11);
        chk("err_quiet", {28'd0, bm, vm, bl, vl}, 0);
        step();
        chk("err_once", {30'd0, em, el}, 0);
        chk("err_idle", {28'd0, bm, vm, bl, vl}, 0);
      end else begin
        data[vecs[i].bank] = rnd256();
        readout(vecs[i].bank, i % 3, -1, -1);
      end
    end

    readout(2, 1, -1, -1);
    readout(3, 0, -1, 5);
    data[3] = rnd256();
    readout(3, 0, 11, -1);
    data[0] = rnd256();
    readout(0, 0, -1, -1);

    for (int r = 0; r < 6; r++) begin
      int b;
      b = $urandom_range(0, 7);
      data[b] = rnd256();
      readout(b, 2, -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
